// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between a fetch requester and a data read/write requester.
// Grants from IDLE and holds each access until ram_ready; `define ARB_FAIR_EN enables fetch starvation control.
module mem_port_arbiter #(
  parameter int STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_word,
  output logic        if_valid,
  input  logic        d_read,
  input  logic [31:0] d_r_addr,
  output logic [31:0] d_r_line,
  input  logic        d_write,
  input  logic [31:0] d_w_addr,
  input  logic [31:0] d_w_line,
  output logic        d_done,
  output logic        stall,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_w_line,
  input  logic [31:0] ram_r_line,
  output logic        ram_read,
  output logic        ram_write,
  input  logic        ram_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DREAD  = 2'd2,
    DWRITE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] ram_addr_q, ram_w_line_q, d_w_addr_q, if_word_q, d_r_line_q;
  logic        wr_pend_q;
  logic        grant_data, grant_fetch, rd_done, data_pend, fetch_first;

  assign data_pend = d_read | d_write;

`ifdef ARB_FAIR_EN
  localparam logic [2:0] LIM = 3'(STARVE_LIM);
  logic [2:0] starve_q;

  // Counts data grants that bypassed a waiting fetch; saturates at 7.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 3'd0;
    end else if (grant_fetch) begin
      starve_q <= 3'd0;
    end else if (grant_data && if_req && (starve_q != 3'd7)) begin
      starve_q <= starve_q + 3'd1;
    end
  end

  assign fetch_first = if_req && (starve_q >= LIM);
`else
  assign fetch_first = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    rd_done     = 1'b0;
    if_valid    = 1'b0;
    d_done      = 1'b0;
    ram_read    = 1'b0;
    ram_write   = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_pend && !fetch_first) begin
          grant_data = 1'b1;
          state_d    = d_read ? DREAD : DWRITE;
        end else if (if_req) begin
          grant_fetch = 1'b1;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        ram_read = 1'b1;
        if (ram_ready) begin
          if_valid = 1'b1;
          state_d  = IDLE;
        end
      end
      DREAD: begin
        ram_read = 1'b1;
        if (ram_ready) begin
          rd_done = 1'b1;
          d_done  = !wr_pend_q;
          state_d = wr_pend_q ? DWRITE : IDLE;
        end
      end
      DWRITE: begin
        ram_write = 1'b1;
        if (ram_ready) begin
          d_done  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset abandons any access without completing it.
    if (rst) begin
      state_d     = IDLE;
      grant_data  = 1'b0;
      grant_fetch = 1'b0;
      rd_done     = 1'b0;
      if_valid    = 1'b0;
      d_done      = 1'b0;
      ram_read    = 1'b0;
      ram_write   = 1'b0;
    end
  end

  assign stall = !rst && ((((state_q == DREAD) || (state_q == DWRITE)) && !d_done) ||
                          ((state_q == IDLE) && data_pend));

  // ram_addr is loaded at grant so it stays put through wait states and idles at its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr_q   <= 32'd0;
      ram_w_line_q <= 32'd0;
      d_w_addr_q   <= 32'd0;
      wr_pend_q    <= 1'b0;
      if_word_q    <= 32'd0;
      d_r_line_q   <= 32'd0;
    end else begin
      if (grant_data) begin
        ram_addr_q <= d_read ? d_r_addr : d_w_addr;
        d_w_addr_q <= d_w_addr;
        wr_pend_q  <= d_read & d_write;
        if (d_write) begin
          ram_w_line_q <= d_w_line;
        end
      end else if (grant_fetch) begin
        ram_addr_q <= if_addr;
      end
      if (rd_done && wr_pend_q) begin
        ram_addr_q <= d_w_addr_q;
        wr_pend_q  <= 1'b0;
      end
      if (if_valid) begin
        if_word_q <= ram_r_line;
      end
      if (rd_done) begin
        d_r_line_q <= ram_r_line;
      end
    end
  end

  assign if_word    = if_valid ? ram_r_line : if_word_q;
  assign d_r_line   = rd_done ? ram_r_line : d_r_line_q;
  assign ram_addr   = ram_addr_q;
  assign ram_w_line = ram_w_line_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL take parameter STARVE_LIM, default 4, meaning the maximum number of consecutive data grants while a fetch is pending.
REQ-002 SHALL have ports `clk` (in, 1, clock) and `rst` (in, 1, reset); one clock; reset is synchronous and active-high.
REQ-003 SHALL have fetch ports: `if_req` in 1 (fetch request); `if_addr` in 32 (fetch address); `if_word` out 32 (fetched word); `if_valid` out 1 (fetch complete).
REQ-004 SHALL have data read ports: `d_read` in 1 (read request); `d_r_addr` in 32 (read address); `d_r_line` out 32 (read data).
REQ-005 SHALL have data write ports: `d_write` in 1 (write request); `d_w_addr` in 32 (write address); `d_w_line` in 32 (write data).
REQ-006 SHALL have `d_done` out 1 (data access complete) and `stall` out 1 (hold decode/memory stages).
REQ-007 SHALL have RAM ports: `ram_addr` out 32; `ram_w_line` out 32; `ram_r_line` in 32; `ram_read` out 1; `ram_write` out 1; `ram_ready` in 1 (access completes this cycle).

Function
REQ-008 SHALL implement the FSM states IDLE, FETCH, DREAD and DWRITE; the state is registered.
REQ-009 In IDLE, SHALL grant on the clock edge:
- data pending (d_read|d_write) -> DREAD if d_read, else DWRITE;
- else if_req -> FETCH;
- else stay in IDLE.
REQ-010 At grant, SHALL latch the address(es) and `d_w_line`; request inputs and address inputs are ignored outside IDLE.
REQ-011 In FETCH, SHALL drive ram_read=1 and ram_addr=latched if_addr; in DREAD, ram_read=1 and ram_addr=latched d_r_addr.
REQ-012 In DWRITE, SHALL drive ram_write=1, ram_addr=latched d_w_addr and ram_w_line=latched d_w_line.
REQ-013 In IDLE, SHALL drive ram_read=0 and ram_write=0; ram_addr and ram_w_line hold their last values.
REQ-014 SHALL stay in an access state while ram_ready=0; the RAM control outputs remain stable during the wait.
REQ-015 On FETCH with ram_ready=1, SHALL:
- assert if_valid combinationally in that cycle, with if_word=ram_r_line;
- register ram_r_line into if_word, which is held afterwards;
- go to IDLE.
REQ-016 On DREAD with ram_ready=1, SHALL register ram_r_line into d_r_line (held afterwards; d_r_line=ram_r_line in that cycle). Then:
- if a write was latched, go to DWRITE with no d_done;
- else assert d_done combinationally and go to IDLE.
REQ-017 On DWRITE with ram_ready=1, SHALL assert d_done combinationally and go to IDLE.
REQ-018 Minimum latency SHALL be: request seen in IDLE at cycle N, access at N+1, done at N+1 if ram_ready=1 then; read+write completes no earlier than N+2.
REQ-019 Requesters deassert or renew after done; a request still high in IDLE SHALL be treated as new.
REQ-020 stall SHALL be 1 when the state is DREAD or DWRITE and d_done=0, or when the state is IDLE and d_read|d_write=1; otherwise stall SHALL be 0.
REQ-021 if_valid and d_done SHALL never be high in the same cycle; ram_read and ram_write SHALL never be high together.

Reset
REQ-022 rst=1 at a clock edge SHALL force IDLE and clear if_word, d_r_line, ram_addr, ram_w_line, all latched addresses and data, and the starvation counter to 0.
REQ-023 Reset mid-access SHALL abandon the access without asserting if_valid or d_done; while rst=1, ram_read, ram_write, if_valid, d_done and stall SHALL be 0.

Configuration
REQ-024 Macro ARB_FAIR_EN defined SHALL enable starvation control:
- a 3-bit saturating counter increments on each data grant made while if_req=1;
- it clears on each fetch grant;
- when counter>=STARVE_LIM and both a fetch and a data request are pending in IDLE, FETCH is granted instead.
REQ-025 With ARB_FAIR_EN undefined, SHALL use strict data priority per REQ-009 with no counter logic synthesized.

Verification
REQ-026 Fetch only: if_req=1, if_addr=0x100, ram_ready=1, ram_r_line=0xDEADBEEF -> ram_read=1 with ram_addr=0x100 in cycle 1; if_valid=1 and if_word=0xDEADBEEF in cycle 1; if_word holds afterwards.
REQ-027 Read+write: d_read=d_write=1, d_r_addr=0x20, d_w_addr=0x24, d_w_line=0x55, ram_ready=1 -> DREAD(0x20) then DWRITE(0x24, 0x55); d_done only in the second access cycle; stall=1 until d_done.
REQ-028 Wait states: DREAD with ram_ready=0 for 3 cycles, then 1 -> ram_addr stable for 4 cycles; exactly one d_done pulse.
REQ-029 Contention: if_req=1 and d_read=1 held continuously; with ARB_FAIR_EN and STARVE_LIM=4 -> 4 data grants, then 1 fetch, repeating; without ARB_FAIR_EN -> no fetch grant.
REQ-030 Reset mid-DWRITE with ram_ready=0: rst=1 for one cycle -> state IDLE, ram_write=0, d_done never asserted, if_word=d_r_line=0.
